// File: rtl/i2s_rx.sv
// i2s_rx: Philips-format I2S receiver, oversampling BCLK/LRCLK/SDATA in the clk domain.
// Delivers MSB-aligned stereo samples with a one-cycle new_data strobe per committed frame.
module i2s_rx #(
  parameter int DATA_W  = 12,
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              BCLK,
  input  logic              LRCLK,
  input  logic              SDATA,
  output logic [DATA_W-1:0] audio_L,
  output logic [DATA_W-1:0] audio_R,
  output logic              new_data,
  output logic              locked,
  output logic              frame_err
);

  localparam int IDLE_W = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_EDGE = 2'd1;
  localparam logic [1:0] ST_RX        = 2'd2;

  localparam logic [CNT_W:0]    DATA_BITS = (CNT_W+1)'(DATA_W);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic              bclk_s1_r;
  logic              bclk_s2_r;
  logic              bclk_s3_r;
  logic              lr_s1_r;
  logic              lr_s2_r;
  logic              sd_s1_r;
  logic              sd_s2_r;

  logic [1:0]        state_r;
  logic              lr_last_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [DATA_W-1:0] shreg_r;
  logic [DATA_W-1:0] hold_l_r;
  logic              pend_l_r;
  logic [IDLE_W-1:0] idle_cnt_r;

  logic              bclk_rise_s;
  logic              boundary_s;
  logic              timeout_s;
  logic              capture_s;
  logic              slot_ok_s;
  logic [CNT_W:0]    bits_s;
  logic [DATA_W-1:0] shreg_next_s;
  logic [CNT_W-1:0]  cnt_next_s;
  logic [IDLE_W-1:0] idle_next_s;

  // Two-flop synchronisers on all three pins plus a third BCLK flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_s1_r <= 1'b0;
      bclk_s2_r <= 1'b0;
      bclk_s3_r <= 1'b0;
      lr_s1_r   <= 1'b0;
      lr_s2_r   <= 1'b0;
      sd_s1_r   <= 1'b0;
      sd_s2_r   <= 1'b0;
    end else begin
      bclk_s1_r <= BCLK;
      bclk_s2_r <= bclk_s1_r;
      bclk_s3_r <= bclk_s2_r;
      lr_s1_r   <= LRCLK;
      lr_s2_r   <= lr_s1_r;
      sd_s1_r   <= SDATA;
      sd_s2_r   <= sd_s1_r;
    end
  end

  // Edge/boundary detection and next-value arithmetic for the slot datapath
  always_comb begin
    bclk_rise_s = bclk_s2_r & ~bclk_s3_r;
    boundary_s  = bclk_rise_s & (lr_s2_r != lr_last_r);
    timeout_s   = (idle_cnt_r == IDLE_LAST);
    capture_s   = ({1'b0, bit_cnt_r} < DATA_BITS);
    // The boundary bit still belongs to the slot being closed, hence the +1
    bits_s      = {1'b0, bit_cnt_r} + (CNT_W+1)'(1);
    slot_ok_s   = (bits_s >= DATA_BITS);

    if (capture_s) begin
      shreg_next_s = {shreg_r[DATA_W-2:0], sd_s2_r};
    end else begin
      shreg_next_s = shreg_r;
    end

    if (&bit_cnt_r) begin
      cnt_next_s = bit_cnt_r;
    end else begin
      cnt_next_s = bit_cnt_r + CNT_W'(1);
    end

    if (bclk_rise_s) begin
      idle_next_s = {IDLE_W{1'b0}};
    end else begin
      idle_next_s = idle_cnt_r + IDLE_W'(1);
    end
  end

  // Receive FSM, slot deserialiser, frame commit and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      lr_last_r  <= 1'b0;
      bit_cnt_r  <= {CNT_W{1'b0}};
      shreg_r    <= {DATA_W{1'b0}};
      hold_l_r   <= {DATA_W{1'b0}};
      pend_l_r   <= 1'b0;
      idle_cnt_r <= {IDLE_W{1'b0}};
      audio_L    <= {DATA_W{1'b0}};
      audio_R    <= {DATA_W{1'b0}};
      new_data   <= 1'b0;
      frame_err  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      new_data  <= 1'b0;
      frame_err <= 1'b0;
      if (!en || ((state_r != ST_IDLE) && timeout_s)) begin
        // Disable and loss of BCLK share one exit: drop lock, discard pending, hold outputs
        state_r    <= ST_IDLE;
        locked     <= 1'b0;
        pend_l_r   <= 1'b0;
        shreg_r    <= {DATA_W{1'b0}};
        bit_cnt_r  <= {CNT_W{1'b0}};
        idle_cnt_r <= {IDLE_W{1'b0}};
        lr_last_r  <= lr_s2_r;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r    <= ST_WAIT_EDGE;
            locked     <= 1'b0;
            idle_cnt_r <= {IDLE_W{1'b0}};
            lr_last_r  <= lr_s2_r;
          end
          ST_WAIT_EDGE: begin
            idle_cnt_r <= idle_next_s;
            if (bclk_rise_s) begin
              lr_last_r <= lr_s2_r;
            end
            if (boundary_s) begin
              state_r   <= ST_RX;
              locked    <= 1'b1;
              bit_cnt_r <= {CNT_W{1'b0}};
              shreg_r   <= {DATA_W{1'b0}};
              pend_l_r  <= 1'b0;
            end
          end
          ST_RX: begin
            idle_cnt_r <= idle_next_s;
            if (boundary_s) begin
              lr_last_r <= lr_s2_r;
              shreg_r   <= {DATA_W{1'b0}};
              bit_cnt_r <= {CNT_W{1'b0}};
              if (!slot_ok_s) begin
                frame_err <= 1'b1;
                pend_l_r  <= 1'b0;
              end else if (!lr_last_r) begin
                hold_l_r <= shreg_next_s;
                pend_l_r <= 1'b1;
              end else if (pend_l_r) begin
                audio_L  <= hold_l_r;
                audio_R  <= shreg_next_s;
                new_data <= 1'b1;
                pend_l_r <= 1'b0;
              end else begin
                pend_l_r <= 1'b0;
              end
            end else if (bclk_rise_s) begin
              shreg_r   <= shreg_next_s;
              bit_cnt_r <= cnt_next_s;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
